bcd_seq_adder_ctrl: RTL and testbench

BCD_SEQ_ADDER_CTRL -- requirements
Module: bcd_seq_adder_ctrl

---
 rtl/bcd_seq_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_bcd_seq_adder_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd_seq_adder_ctrl.sv
// Sequential packed-BCD adder/subtractor: one decimal digit per clock, LSB first.
// Results are published only when the last digit has been processed.
module bcd_seq_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic [1:0]            state_dbg
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [W-1:0]  a_r, b_r, acc;
    logic          sub_r, carry, err_w;
    logic [IW-1:0] idx;

    logic          last;
    logic          in_err;
    logic [3:0]    a_d, b_d, digit;
    logic [4:0]    t;
    logic          carry_nx;

    assign last = (idx == IW'(DIGITS - 1));

    // Operand validity is judged on the raw inputs at capture time.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                in_err = 1'b1;
        end
    end

    always_comb begin
        a_d      = a_r[3:0];
        b_d      = sub_r ? (4'd9 - b_r[3:0]) : b_r[3:0];
        t        = {1'b0, a_d} + {1'b0, b_d} + {4'b0, carry};
        carry_nx = (t > 5'd9);
        digit    = carry_nx ? (t[3:0] + 4'd6) : t[3:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        state_dbg = state;
    end

    // Datapath: digits shift out of a_r/b_r and into the top of acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            sub_r <= 1'b0;
            carry <= 1'b0;
            err_w <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sub_r <= sub;
                        carry <= sub ? 1'b1 : cin;
                        err_w <= in_err;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> 4;
                    b_r   <= b_r >> 4;
                    acc   <= {digit, acc[W-1:4]};
                    carry <= carry_nx;
                    if (last) begin
                        sum  <= {digit, acc[W-1:4]};
                        cout <= carry_nx;
                        err  <= err_w;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// Directed bench for bcd_seq_adder_ctrl (DIGITS=4): latency, busy width,
// result hold, invalid digits, ignored start and mid-run reset.
module tb_bcd_seq_adder_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_sum;

    bcd_seq_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to completion. With poke set, a
    // second start with different operands is raised while busy.
    task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_sub, input logic op_cin,
                          input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic exp_err, input bit poke);
        int lat, busy_cnt, extra_done;
        logic [W-1:0] sb_exp;
        exp_q.push_back(exp_sum);
        @(negedge clk);
        a = op_a; b = op_b; sub = op_sub; cin = op_cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom_range(0, 65535));
        b = W'($urandom_range(0, 65535));
        sub = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        lat = -1;
        busy_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            if (done) begin
                lat = j;
                break;
            end
            if (busy) busy_cnt++;
            if (j == 2) check({tag, "_hold_mid"}, 32'(sum), 32'(prev_sum));
            start = (poke && j == 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(DIGITS));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DIGITS));
        sb_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_sum"}, 32'(sum), 32'(sb_exp));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_sum_held"}, 32'(sum), 32'(exp_sum));
        extra_done = 0;
        for (int j = 0; j < 8; j++) begin
            if (done) extra_done++;
            @(posedge clk); #1;
        end
        check({tag, "_extra_done"}, 32'(extra_done), 32'd0);
        check({tag, "_sum_final"}, 32'(sum), 32'(exp_sum));
        prev_sum = exp_sum;
    endtask

    initial begin
        int extra_done;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        prev_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_basic",  16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
        run_op("add_ripple", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("add_cin",    16'h0999, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("sub_pos",    16'h0500, 16'h0123, 1'b1, 1'b0, 16'h0377, 1'b1, 1'b0, 1'b0);
        run_op("sub_neg",    16'h0100, 16'h0200, 1'b1, 1'b1, 16'h9900, 1'b0, 1'b0, 1'b0);
        run_op("bad_digit",  16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
        run_op("after_bad",  16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("busy_start", 16'h2500, 16'h2500, 1'b0, 1'b0, 16'h5000, 1'b0, 1'b0, 1'b1);

        // Reset two cycles into RUN aborts the operation.
        @(negedge clk);
        a = 16'h4444; b = 16'h3333; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("midrun_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_busy", 32'(busy), 32'd0);
        check("midrun_sum", 32'(sum), 32'd0);
        check("midrun_done", 32'(done), 32'd0);
        check("midrun_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        extra_done = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        check("midrun_no_done", 32'(extra_done), 32'd0);
        prev_sum = '0;

        run_op("post_rst", 16'h0808, 16'h0303, 1'b0, 1'b1, 16'h1112, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
